div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin arbiter and sequencer that shares one `longdivider` instance (n = 8, unsigned, 2n-cycle shift/subtract) among NREQ requesters. It selects a requester, loads its operands, drives the divider's start/handshake, captures Q/R on Done and returns them with the requester's ID. Divide-by-zero is resolved locally without occupying the divider. The block sits between requester logic and the single divider datapath.

## Interface
- `N`, 8: operand width; must match divider n (divider counter fixed at 2n = 16 cycles).
- `NREQ`, 4: number of requesters.
- `LOGR`, 2: width of `rsp_id`, = log2(NREQ).

- `Clock`  in  1  sole clock, rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; held high until the matching response.
- `dividend`  in  NREQ*N  requester k's operand at bits [k*N +: N]; stable while `req[k]`.
- `divisor`  in  NREQ*N  same packing.
- `gnt`  out  NREQ  one-hot; high from grant until the response cycle inclusive.
- `busy`  out  1  high in any state except IDLE.
- `rsp_valid`  out  1  one-cycle result pulse.
- `rsp_id`  out  LOGR  index of the served requester; valid with `rsp_valid`.
- `rsp_q`, `rsp_r`  out  N each  quotient and remainder; valid with `rsp_valid`.
- `rsp_dz`  out  1  divide-by-zero flag; valid with `rsp_valid`.
- `div_s`, `div_LA`, `div_EB`  out  1 each  divider controls.
- `div_DataA`, `div_DataB`  out  N each  divider operands (registered copy of the winner's).
- `div_Done`  in  1  divider Done (combinational from its S4).
- `div_Q`, `div_R`  in  N each  divider results.

## Operation
- All registered outputs reset to 0. The round-robin pointer resets to NREQ-1, so requester 0 has first priority. The state resets to IDLE. The divider shares `Resetn` and returns to its S1.
- IDLE: if any `req` is high, pick the first set bit searching upward, circularly, from pointer+1.
  - At that edge: set pointer to the winner, register the winner's operands and ID, and set its `gnt` bit.
  - Winner's divisor == 0: go to RESP with `rsp_dz`=1, `rsp_q` = all ones, `rsp_r` = dividend. No divider control is asserted.
  - Otherwise go to LOAD.
- LOAD (1 cycle): `div_LA` = `div_EB` = `div_s` = 1. The divider loads A and B and moves S1->S2 at the edge. Next state is BUSY.
- BUSY: `div_s` = 1, LA and EB = 0. When `div_Done` is sampled high, capture `div_Q`/`div_R` into `rsp_q`/`rsp_r` with `rsp_dz`=0, then go to RESP.
- RESP (1 cycle): `rsp_valid` = 1, `div_s` = 0 (the divider goes S4->S1 at the edge). `gnt` is cleared at the end of the cycle. Next state is IDLE.
- Result registers hold their values until the next capture. `rsp_id` holds its value likewise.
- Late arrivals: a `req` asserted while busy waits. It is never lost.
- Protocol violation: if `req[k]` drops while k is being served, the operation still completes and `rsp_valid` still pulses.
- Reset mid-operation: the controller returns to IDLE immediately with all outputs 0. No response is issued for the aborted operation.

## Timing
- Reference point: `req` is sampled at the edge ending cycle 0, in IDLE.
- Normal division, cycle by cycle:
  - Cycle 1: LOAD.
  - Cycles 2–17: divider S2/S3.
  - Cycle 18: `div_Done`=1.
  - Cycle 19: `rsp_valid`.
  - Cycle 20: IDLE.
  - Next LOAD no earlier than cycle 21.
- Latency is 2N+3 cycles from sample to `rsp_valid`. Throughput is one operation per 2N+4 cycles.
- Divide-by-zero: `rsp_valid` in cycle 1, IDLE in cycle 2.
- `div_s` is never high in RESP or IDLE. This guarantees at least one S1 cycle between divider operations.
- Outputs are registered, except `div_*` controls, which decode directly from state.

## Test plan
- Single operation: `req[0]`, 100/7 -> `rsp_valid` in cycle 19, `rsp_id`=0, q=14, r=2, dz=0. `div_s` is high in cycles 1–18 only.
- Round robin: `req`=4'b1111, all held, each with distinct operands -> responses in ID order 0,1,2,3,0. Each result is correct, and consecutive `rsp_valid` pulses are 20 cycles apart.
- Divide by zero: `req[2]`, 55/0 -> `rsp_valid` in cycle 1, q=8'hFF, r=55, dz=1, `div_s`/`div_LA` never asserted.
- Late arrival and fairness:
  - With `req[3]` in service, raise `req[1]`, then `req[2]` -> served 1 then 2.
  - 255/1 -> q=255, r=0.
  - 5/9 -> q=0, r=5.
- Reset mid-operation: pull `Resetn` low in cycle 10 of a division -> all outputs are 0 and the state is IDLE at once, with no `rsp_valid`. After release, a new 200/3 request returns q=66, r=2 with normal latency.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Requester-side bus of div_arbiter: per-requester request and operands in,
// one-hot grant and a tagged quotient/remainder response out.
interface div_arbiter_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LOGR = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] dividend;
  logic [NREQ*N-1:0] divisor;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [LOGR-1:0]   rsp_id;
  logic [N-1:0]      rsp_q;
  logic [N-1:0]      rsp_r;
  logic              rsp_dz;

  // Requester side
  modport master (
    output req, dividend, divisor,
    input  gnt, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz
  );

  // Arbiter side
  modport slave (
    input  req, dividend, divisor,
    output gnt, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing one 2N-cycle long divider among NREQ
// requesters. Divide-by-zero is answered locally without touching the divider.
module div_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LOGR = 2
) (
  input  logic         Clock,
  input  logic         Resetn,
  div_arbiter_if.slave bus,
  output logic         busy,
  output logic         div_s,
  output logic         div_LA,
  output logic         div_EB,
  output logic [N-1:0] div_DataA,
  output logic [N-1:0] div_DataB,
  input  logic         div_Done,
  input  logic [N-1:0] div_Q,
  input  logic [N-1:0] div_R
);

  typedef enum logic [1:0] {StIdle, StLoad, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic [LOGR-1:0]   ptr_q;
  logic [LOGR-1:0]   id_q;
  logic [NREQ-1:0]   gnt_q;
  logic [N-1:0]      a_q, b_q;
  logic [N-1:0]      quot_q, rem_q;
  logic              dz_q;
  logic              valid_q;

  logic              any_req;
  logic [LOGR-1:0]   win;
  logic [LOGR-1:0]   idx;
  logic [N-1:0]      win_a, win_b;

  // Circular search for the first request above the last winner; the pointer
  // itself is checked last so the previous winner has lowest priority.
  always_comb begin
    any_req = 1'b0;
    win     = ptr_q;
    idx     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = ptr_q + LOGR'(i);
      if (!any_req && bus.req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  assign win_a = bus.dividend[win*N +: N];
  assign win_b = bus.divisor[win*N +: N];

  // Next state and divider controls decoded straight from the state
  always_comb begin
    state_d = state_q;
    div_s   = 1'b0;
    div_LA  = 1'b0;
    div_EB  = 1'b0;
    case (state_q)
      StIdle: begin
        if (any_req) state_d = (win_b == '0) ? StResp : StLoad;
      end
      StLoad: begin
        div_s   = 1'b1;
        div_LA  = 1'b1;
        div_EB  = 1'b1;
        state_d = StBusy;
      end
      StBusy: begin
        div_s = 1'b1;
        if (div_Done) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, grant, operand and result registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      ptr_q   <= LOGR'(NREQ - 1);
      id_q    <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == StResp);
      case (state_q)
        StIdle: begin
          if (any_req) begin
            ptr_q <= win;
            id_q  <= win;
            a_q   <= win_a;
            b_q   <= win_b;
            gnt_q <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            if (win_b == '0) begin
              quot_q <= '1;
              rem_q  <= win_a;
              dz_q   <= 1'b1;
            end
          end
        end
        StBusy: begin
          if (div_Done) begin
            quot_q <= div_Q;
            rem_q  <= div_R;
            dz_q   <= 1'b0;
          end
        end
        StResp:  gnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != StIdle);
  assign div_DataA     = a_q;
  assign div_DataB     = b_q;
  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_q     = quot_q;
  assign bus.rsp_r     = rem_q;
  assign bus.rsp_dz    = dz_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural 2N-cycle long divider.
module tb_div_arbiter;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       busy;
  logic       div_s, div_LA, div_EB;
  logic [7:0] div_DataA, div_DataB;
  logic       div_Done;
  logic [7:0] div_Q, div_R;

  int tests = 0;
  int fails = 0;

  div_arbiter_if #(.N(8), .NREQ(4), .LOGR(2)) bus ();

  div_arbiter #(.N(8), .NREQ(4), .LOGR(2)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .bus       (bus),
    .busy      (busy),
    .div_s     (div_s),
    .div_LA    (div_LA),
    .div_EB    (div_EB),
    .div_DataA (div_DataA),
    .div_DataB (div_DataB),
    .div_Done  (div_Done),
    .div_Q     (div_Q),
    .div_R     (div_R)
  );

  always #5 Clock = ~Clock;

  // Divider model: S1 idle/load, 16 cycles in S2/S3, S4 with Done until s drops
  int         dst;
  int         dcnt;
  logic [7:0] ra, rb, dq, dr;
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      dst  <= 0;
      dcnt <= 0;
      ra   <= '0;
      rb   <= '0;
      dq   <= '0;
      dr   <= '0;
    end else begin
      case (dst)
        0: begin
          if (div_LA) ra <= div_DataA;
          if (div_EB) rb <= div_DataB;
          if (div_s) begin
            dst  <= 1;
            dcnt <= 0;
          end
        end
        1: begin
          dcnt <= dcnt + 1;
          if (dcnt == 15) begin
            dst <= 2;
            dq  <= (rb == 0) ? 8'hFF : ra / rb;
            dr  <= (rb == 0) ? ra : ra % rb;
          end
        end
        default: if (!div_s) dst <= 0;
      endcase
    end
  end
  assign div_Done = (dst == 2);
  assign div_Q    = dq;
  assign div_R    = dr;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
    bus.dividend[k*8 +: 8] = a;
    bus.divisor[k*8 +: 8]  = b;
  endtask

  // Advance until rsp_valid, returning the number of cycles stepped
  task automatic wait_rsp(input int limit, output int n);
    n = 0;
    while (!bus.rsp_valid && n < limit) begin
      tick();
      n++;
    end
    chk("rsp timeout", {31'd0, bus.rsp_valid}, 32'd1);
  endtask

  int n;
  int exp_id[5] = '{0, 1, 2, 3, 0};
  int exp_q[4]  = '{14, 22, 9, 15};
  int exp_r[4]  = '{2, 2, 5, 10};
  logic seen_valid;

  initial begin
    Resetn       = 1'b0;
    bus.req      = '0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) tick();

    // Reset state
    chk("reset gnt", {28'd0, bus.gnt}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset div_s", {31'd0, div_s}, 32'd0);
    chk("reset rsp_q", {24'd0, bus.rsp_q}, 32'd0);
    Resetn = 1'b1;

    // Round robin from reset: all four held, order 0,1,2,3,0, 20 cycles apart
    set_op(0, 8'd100, 8'd7);
    set_op(1, 8'd200, 8'd9);
    set_op(2, 8'd77, 8'd8);
    set_op(3, 8'd250, 8'd16);
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick();
      wait_rsp(40, n);
      chk("rr spacing", n, 19);
      chk("rr id", {30'd0, bus.rsp_id}, exp_id[j]);
      chk("rr q", {24'd0, bus.rsp_q}, exp_q[exp_id[j]]);
      chk("rr r", {24'd0, bus.rsp_r}, exp_r[exp_id[j]]);
      chk("rr gnt", {28'd0, bus.gnt}, 32'd1 << exp_id[j]);
      if (j == 4) bus.req = 4'b0000;
    end
    tick();

    // Single operation 100/7 on requester 0, cycle by cycle
    chk("idle busy", {31'd0, busy}, 32'd0);
    bus.req = 4'b0001;
    tick();
    chk("load div_s", {31'd0, div_s}, 32'd1);
    chk("load div_LA", {31'd0, div_LA}, 32'd1);
    chk("load div_EB", {31'd0, div_EB}, 32'd1);
    chk("load DataA", {24'd0, div_DataA}, 32'd100);
    chk("load DataB", {24'd0, div_DataB}, 32'd7);
    chk("load gnt", {28'd0, bus.gnt}, 32'd1);
    for (int c = 2; c <= 18; c++) begin
      tick();
      chk("busy div_s", {31'd0, div_s}, 32'd1);
      chk("busy div_LA", {31'd0, div_LA}, 32'd0);
      chk("busy valid", {31'd0, bus.rsp_valid}, 32'd0);
    end
    chk("cycle18 done", {31'd0, div_Done}, 32'd1);
    tick();
    chk("c19 valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("c19 id", {30'd0, bus.rsp_id}, 32'd0);
    chk("c19 q", {24'd0, bus.rsp_q}, 32'd14);
    chk("c19 r", {24'd0, bus.rsp_r}, 32'd2);
    chk("c19 dz", {31'd0, bus.rsp_dz}, 32'd0);
    chk("c19 div_s", {31'd0, div_s}, 32'd0);
    chk("c19 gnt", {28'd0, bus.gnt}, 32'd1);
    bus.req = 4'b0000;
    tick();
    chk("c20 valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("c20 busy", {31'd0, busy}, 32'd0);
    chk("c20 gnt", {28'd0, bus.gnt}, 32'd0);
    chk("c20 q held", {24'd0, bus.rsp_q}, 32'd14);

    // Divide by zero on requester 2
    set_op(2, 8'd55, 8'd0);
    bus.req = 4'b0100;
    tick();
    chk("dz valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("dz id", {30'd0, bus.rsp_id}, 32'd2);
    chk("dz q", {24'd0, bus.rsp_q}, 32'hFF);
    chk("dz r", {24'd0, bus.rsp_r}, 32'd55);
    chk("dz flag", {31'd0, bus.rsp_dz}, 32'd1);
    chk("dz div_s", {31'd0, div_s}, 32'd0);
    chk("dz div_LA", {31'd0, div_LA}, 32'd0);
    chk("dz gnt", {28'd0, bus.gnt}, 32'd4);
    bus.req = 4'b0000;
    tick();
    chk("dz idle", {31'd0, busy}, 32'd0);
    chk("dz div_s after", {31'd0, div_s}, 32'd0);

    // Late arrivals while 3 is in service: served 1 then 2
    set_op(3, 8'd255, 8'd1);
    set_op(1, 8'd5, 8'd9);
    set_op(2, 8'd13, 8'd4);
    bus.req = 4'b1000;
    repeat (5) tick();
    bus.req[1] = 1'b1;
    repeat (3) tick();
    bus.req[2] = 1'b1;
    wait_rsp(40, n);
    chk("late3 lat", n, 11);
    chk("late3 id", {30'd0, bus.rsp_id}, 32'd3);
    chk("late3 q", {24'd0, bus.rsp_q}, 32'd255);
    chk("late3 r", {24'd0, bus.rsp_r}, 32'd0);
    bus.req[3] = 1'b0;
    tick();
    wait_rsp(40, n);
    chk("late1 lat", n, 19);
    chk("late1 id", {30'd0, bus.rsp_id}, 32'd1);
    chk("late1 q", {24'd0, bus.rsp_q}, 32'd0);
    chk("late1 r", {24'd0, bus.rsp_r}, 32'd5);
    bus.req[1] = 1'b0;
    tick();
    wait_rsp(40, n);
    chk("late2 lat", n, 19);
    chk("late2 id", {30'd0, bus.rsp_id}, 32'd2);
    chk("late2 q", {24'd0, bus.rsp_q}, 32'd3);
    chk("late2 r", {24'd0, bus.rsp_r}, 32'd1);
    bus.req[2] = 1'b0;
    tick();

    // Reset in cycle 10 of a division, then 200/3 after release
    set_op(0, 8'd100, 8'd7);
    bus.req = 4'b0001;
    repeat (10) tick();
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    Resetn = 1'b0;
    #1;
    chk("mid-reset busy", {31'd0, busy}, 32'd0);
    chk("mid-reset gnt", {28'd0, bus.gnt}, 32'd0);
    chk("mid-reset div_s", {31'd0, div_s}, 32'd0);
    chk("mid-reset DataA", {24'd0, div_DataA}, 32'd0);
    chk("mid-reset rsp_q", {24'd0, bus.rsp_q}, 32'd0);
    bus.req = 4'b0000;
    seen_valid = 1'b0;
    repeat (4) begin
      tick();
      seen_valid = seen_valid | bus.rsp_valid;
    end
    chk("no aborted rsp", {31'd0, seen_valid}, 32'd0);
    Resetn = 1'b1;
    set_op(0, 8'd200, 8'd3);
    bus.req = 4'b0001;
    wait_rsp(40, n);
    chk("post-reset lat", n, 19);
    chk("post-reset id", {30'd0, bus.rsp_id}, 32'd0);
    chk("post-reset q", {24'd0, bus.rsp_q}, 32'd66);
    chk("post-reset r", {24'd0, bus.rsp_r}, 32'd2);
    bus.req = 4'b0000;
    tick();
    chk("final idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
